ro_puf_bank: RTL and testbench

- Parametrised successor to the single emulated ring oscillator.
- Instantiates N_CH emulated ring oscillators of STAGES inverting stages. Each channel advances at its own divided tick rate, giving a distinct emulated delay.
- A measurement FSM counts rising edges of every channel over a fixed window of clk cycles. Results are read out through a select mux.
- Sits between the oscillator layer and the PUF response/comparison logic.

---
 rtl/ro_puf_bank.sv | 181 ++++++++++++++++++
 tb/tb_ro_puf_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_bank.sv
// Bank of N_CH emulated ring oscillators with a windowed rising-edge counter per channel.
// Optional challenge comparator (resp_o) is compiled in when RO_PUF_CHALLENGE_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start_i; counters hold their reset value
// S_MEASURE | window open; rising edges accumulate, busy_o high
// S_DONE    | window closed; counters frozen, done_o high until next start
module ro_puf_bank #(
  parameter  int N_CH     = 4,
  parameter  int STAGES   = 15,
  parameter  int DIV_BASE = 4,
  parameter  int DIV_STEP = 1,
  parameter  int WINDOW   = 256,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [SEL_W-1:0] sel_i,
`ifdef RO_PUF_CHALLENGE_EN
  input  logic [SEL_W-1:0] chal_a_i,
  input  logic [SEL_W-1:0] chal_b_i,
  output logic             resp_o,
`endif
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int DIV_MAX = DIV_BASE + (N_CH - 1) * DIV_STEP;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [STAGES-1:0] seed_f();
    logic [STAGES-1:0] s;
    for (int k = 0; k < STAGES; k++) begin
      s[k] = ~k[0];
    end
    return s;
  endfunction

  localparam logic [STAGES-1:0] SEED = seed_f();

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  logic [N_CH-1:0] rise;

  // Oscillator channels run independently of the FSM, including while idle.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam int DIV_G = DIV_BASE + g * DIV_STEP;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_G - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [STAGES-1:0] ring_q, ring_d;
    logic              prev_q;
    logic              tick;
    logic              osc;

    assign tick    = (div_q == DIV_LAST);
    assign osc     = ring_q[STAGES-1];
    assign rise[g] = osc & ~prev_q;

    always_comb begin
      div_d  = tick ? '0 : div_q + DIV_W'(1);
      ring_d = ring_q;
      if (tick) begin
        ring_d = {~ring_q[STAGES-2:0], ~(enable_i & ring_q[STAGES-1])};
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        div_q  <= '0;
        ring_q <= SEED;
        prev_q <= SEED[STAGES-1];
      end else begin
        div_q  <= div_d;
        ring_q <= ring_d;
        prev_q <= osc;
      end
    end
  end

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
`ifdef RO_PUF_CHALLENGE_EN
  logic             resp_q, resp_d;
  logic [CNT_W-1:0] chal_a_cnt, chal_b_cnt;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
`ifdef RO_PUF_CHALLENGE_EN
    resp_d     = resp_q;
    chal_a_cnt = '0;
    chal_b_cnt = '0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_MEASURE;
          win_d   = '0;
          for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
          end
`ifdef RO_PUF_CHALLENGE_EN
          resp_d = 1'b0;
`endif
        end
      end
      S_MEASURE: begin
        for (int i = 0; i < N_CH; i++) begin
          if (rise[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        win_d = win_q + WIN_W'(1);
        if (win_q == WIN_LAST) begin
          state_d = S_DONE;
`ifdef RO_PUF_CHALLENGE_EN
          // Compare the updated counts so the edge on the closing cycle is included.
          for (int i = 0; i < N_CH; i++) begin
            if (chal_a_i == SEL_W'(i)) chal_a_cnt = cnt_d[i];
            if (chal_b_i == SEL_W'(i)) chal_b_cnt = cnt_d[i];
          end
          resp_d = (chal_a_cnt > chal_b_cnt);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef RO_PUF_CHALLENGE_EN
      resp_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
`ifdef RO_PUF_CHALLENGE_EN
      resp_q <= resp_d;
`endif
    end
  end

  // Select values beyond the last channel read back as zero.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_i == SEL_W'(i)) count_o = cnt_q[i];
    end
  end

  assign busy_o = (state_q == S_MEASURE);
  assign done_o = (state_q == S_DONE);
`ifdef RO_PUF_CHALLENGE_EN
  assign resp_o = resp_q;
`endif

endmodule

// File: tb/tb_ro_puf_bank.sv
// Directed bench for ro_puf_bank: four instances (fast rings, enable-low defaults,
// default challenge setup, narrow saturating counters) sharing clock and reset.
module tb_ro_puf_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // a: STAGES=3, DIV 1..4, WINDOW=60
  logic        en_a, start_a, busy_a, done_a;
  logic [1:0]  sel_a;
  logic [15:0] count_a;
  // b: defaults, enable low
  logic        en_b, start_b, busy_b, done_b;
  logic [1:0]  sel_b;
  logic [15:0] count_b;
  // c: defaults, enable high
  logic        en_c, start_c, busy_c, done_c;
  logic [1:0]  sel_c;
  logic [15:0] count_c;
  // s: N_CH=3, CNT_W=3, WINDOW=200
  logic        en_s, start_s, busy_s, done_s;
  logic [1:0]  sel_s;
  logic [2:0]  count_s;
`ifdef RO_PUF_CHALLENGE_EN
  logic [1:0]  chal_a_c, chal_b_c;
  logic        resp_a, resp_b, resp_c, resp_s;
`endif

  ro_puf_bank #(.N_CH(4), .STAGES(3), .DIV_BASE(1), .DIV_STEP(1), .WINDOW(60), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en_a), .start_i(start_a), .sel_i(sel_a),
`ifdef RO_PUF_CHALLENGE_EN
    .chal_a_i(2'd0), .chal_b_i(2'd1), .resp_o(resp_a),
`endif
    .count_o(count_a), .busy_o(busy_a), .done_o(done_a));

  ro_puf_bank u_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en_b), .start_i(start_b), .sel_i(sel_b),
`ifdef RO_PUF_CHALLENGE_EN
    .chal_a_i(2'd0), .chal_b_i(2'd1), .resp_o(resp_b),
`endif
    .count_o(count_b), .busy_o(busy_b), .done_o(done_b));

  ro_puf_bank u_c (
    .clk_i(clk), .rst_i(rst), .enable_i(en_c), .start_i(start_c), .sel_i(sel_c),
`ifdef RO_PUF_CHALLENGE_EN
    .chal_a_i(chal_a_c), .chal_b_i(chal_b_c), .resp_o(resp_c),
`endif
    .count_o(count_c), .busy_o(busy_c), .done_o(done_c));

  ro_puf_bank #(.N_CH(3), .STAGES(3), .DIV_BASE(1), .DIV_STEP(1), .WINDOW(200), .CNT_W(3)) u_s (
    .clk_i(clk), .rst_i(rst), .enable_i(en_s), .start_i(start_s), .sel_i(sel_s),
`ifdef RO_PUF_CHALLENGE_EN
    .chal_a_i(2'd0), .chal_b_i(2'd1), .resp_o(resp_s),
`endif
    .count_o(count_s), .busy_o(busy_s), .done_o(done_s));

  int lat, nbusy, ndone;

  initial begin
    rst = 1'b1;
    en_a = 1'b1; en_b = 1'b0; en_c = 1'b1; en_s = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_s = 1'b0;
    sel_a = 2'd0; sel_b = 2'd0; sel_c = 2'd0; sel_s = 2'd0;
`ifdef RO_PUF_CHALLENGE_EN
    chal_a_c = 2'd0; chal_b_c = 2'd3;
`endif
    repeat (2) @(negedge clk);

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      #1 chk($sformatf("rst_count%0d", i), count_a, 0);
    end
`ifdef RO_PUF_CHALLENGE_EN
    chk("rst_resp", {resp_a, resp_b, resp_c, resp_s}, 0);
`endif
    rst = 1'b0;

    // saturation instance: start sampled at cycle 11, done at cycle 211
    while (cyc < 10) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;

    // challenge instance: start sampled at cycle 120; ch0 rises at 120,240,360, ch3 at 210
    while (cyc < 119) @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;

    // basic window on a
    start_a = 1'b1; lat = 0; nbusy = 0;
    for (int k = 1; k <= 80 && lat == 0; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (busy_a) nbusy++;
      if (done_a) lat = k;
    end
    chk("a_latency", lat, 61);
    chk("a_busy_cycles", nbusy, 60);
    sel_a = 2'd0; #1 chk("a_count0", count_a, 10);
    sel_a = 2'd1; #1 chk("a_count1", count_a, 5);
    repeat (20) @(negedge clk);
    sel_a = 2'd0; #1 chk("a_frozen0", count_a, 10);
    chk("a_done_held", done_a, 1);

    // saturation
    for (int k = 0; k < 100 && !done_s; k++) @(negedge clk);
    chk("s_done", done_s, 1);
    sel_s = 2'd0; #1 chk("s_sat0", count_s, 7);
    sel_s = 2'd1; #1 chk("s_sat1", count_s, 7);
    sel_s = 2'd3; #1 chk("s_sel_oob", count_s, 0);

    // challenge instance results
    for (int k = 0; k < 400 && !done_c; k++) @(negedge clk);
    chk("c_done", done_c, 1);
    sel_c = 2'd0; #1 chk("c_count0", count_c, 3);
    sel_c = 2'd1; #1 chk("c_count1", count_c, 2);
    sel_c = 2'd3; #1 chk("c_count3", count_c, 1);
`ifdef RO_PUF_CHALLENGE_EN
    chk("c_resp_0gt3", resp_c, 1);
    chal_a_c = 2'd3; chal_b_c = 2'd0;
`endif
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    chk("c_restart_busy", busy_c, 1);
    chk("c_restart_done", done_c, 0);
`ifdef RO_PUF_CHALLENGE_EN
    chk("c_resp_cleared", resp_c, 0);
`endif
    for (int k = 0; k < 300 && !done_c; k++) @(negedge clk);
    chk("c_done2", done_c, 1);
`ifdef RO_PUF_CHALLENGE_EN
    chk("c_resp_3gt0", resp_c, 0);
`endif

    // enable low: rings stay at the seed pattern, no edges
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 300 && !done_b; k++) @(negedge clk);
    chk("b_done", done_b, 1);
    for (int i = 0; i < 4; i++) begin
      sel_b = 2'(i);
      #1 chk($sformatf("b_count%0d", i), count_b, 0);
    end

    // start during MEASURE is ignored
    start_a = 1'b1; lat = 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge clk);
      start_a = (k == 30);
      if (k == 1) begin
        chk("a_restart_done", done_a, 0);
        chk("a_restart_busy", busy_a, 1);
      end
      if (done_a) lat = k;
    end
    chk("a_ignore_start_latency", lat, 61);
    sel_a = 2'd0; #1 chk("a2_count0", count_a, 10);
    sel_a = 2'd1; #1 chk("a2_count1", count_a, 5);

    // reset in the middle of a window
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (29) @(negedge clk);
    chk("a_mid_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("a_rst_no_done", ndone, 0);
    chk("a_rst_busy", busy_a, 0);
    sel_a = 2'd0; #1 chk("a_rst_count0", count_a, 0);
    sel_a = 2'd1; #1 chk("a_rst_count1", count_a, 0);

    // start and reset together: reset wins
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    @(negedge clk);
    chk("a_rst_start_busy", busy_a, 0);
    chk("a_rst_start_done", done_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
